// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side packer.
// The packer's optional partial flush is enabled with PACKER_FLUSH_TIMEOUT_EN.
package fifo_rd_packer_pkg;

    localparam int FIFO_WIDTH      = 16;
    localparam int OUT_WIDTH       = 2 * FIFO_WIDTH;
    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {S_LO, S_HI, S_OUT} pack_state_e;

    typedef logic [OUT_WIDTH-1:0] packed_word_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops 16-bit FIFO words in pairs and emits them as {second, first} on a valid/ready stream.
// Define PACKER_FLUSH_TIMEOUT_EN to flush a lone low half after TIMEOUT_CYC idle cycles.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int IN_WIDTH    = FIFO_WIDTH,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [IN_WIDTH-1:0]   fifo_dout,
    output logic                  fifo_rd_en,
    output logic [2*IN_WIDTH-1:0] m_data,
    output logic [1:0]            m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int OUT_W = 2 * IN_WIDTH;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("fifo_rd_packer: TIMEOUT_CYC must be at least 2");
    end

    pack_state_e          state_q, state_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [IN_WIDTH-1:0]  lo_q, lo_d;
    logic [OUT_W-1:0]     m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 flush;
    logic                 accept;

    assign accept = m_valid_q && m_ready;

`ifdef PACKER_FLUSH_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [1:0]        m_keep_q, m_keep_d;
    logic              idle_now;

    // An idle cycle is one in S_HI where nothing is in flight and nothing can be popped.
    assign idle_now = (state_q == S_HI) && fifo_empty && !rd_pend_q;
    assign flush    = idle_now && (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    always_comb begin
        idle_d = '0;
        if (idle_now && !flush) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_keep_q <= 2'b11;
        end else begin
            m_keep_q <= m_keep_d;
        end
    end

    assign m_keep = m_keep_q;
`else
    assign flush  = 1'b0;
    assign m_keep = 2'b11;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LO:    if (rd_pend_q)           state_d = S_HI;
            S_HI:    if (rd_pend_q || flush)  state_d = S_OUT;
            S_OUT:   if (accept)              state_d = S_LO;
            default:                          state_d = S_LO;
        endcase
    end

    // Output and datapath logic; the pop request depends only on registered state and fifo_empty.
    always_comb begin
        fifo_rd_en = (state_q != S_OUT) && !fifo_empty && !rd_pend_q;
        rd_pend_d  = fifo_rd_en;
        lo_d       = lo_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        word_cnt_d = word_cnt_q;
`ifdef PACKER_FLUSH_TIMEOUT_EN
        m_keep_d   = m_keep_q;
`endif
        if ((state_q == S_LO) && rd_pend_q) begin
            lo_d = fifo_dout;
        end
        if ((state_q == S_HI) && rd_pend_q) begin
            m_data_d  = {fifo_dout, lo_q};
            m_valid_d = 1'b1;
`ifdef PACKER_FLUSH_TIMEOUT_EN
            m_keep_d  = 2'b11;
`endif
        end else if (flush) begin
            m_data_d  = {IN_WIDTH'(0), lo_q};
            m_valid_d = 1'b1;
`ifdef PACKER_FLUSH_TIMEOUT_EN
            m_keep_d  = 2'b01;
`endif
        end
        if ((state_q == S_OUT) && accept) begin
            m_valid_d = 1'b0;
            if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q  <= 1'b0;
            lo_q       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            lo_q       <= lo_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO feeds the DUT and a pair-in-write-order scoreboard checks its output.
module tb_fifo_rd_packer;

    localparam int IW    = 16;
    localparam int OW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [IW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic [OW-1:0] m_data;
    logic [1:0]    m_keep;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [CW-1:0] word_cnt;

    always #5 clk = ~clk;

    fifo_rd_packer #(.IN_WIDTH(IW), .TIMEOUT_CYC(16), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [IW-1:0] fq[$];
    logic [OW-1:0] exp_q[$];
    logic [1:0]    exp_keep_q[$];
    bit            half_vld;
    logic [IW-1:0] half;
    int            rd_cnt = 0;
    int            vld_cnt = 0;
    int            xfer_cnt = 0;
    bit            hold_prev;
    logic [OW-1:0] hold_data;
    logic [1:0]    hold_keep;
    int            ready_mode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(1, 0));
        endcase
    endtask

    // One clock: observe at the falling edge, then update FIFO model and inputs just after the rising edge.
    task automatic cycle();
        bit pop_now;
        @(negedge clk);
        pop_now = 1'b0;
        if (rst_n) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                chk("no_underflow", 64'(fifo_empty), 64'(0));
                pop_now = 1'b1;
            end
            if (m_valid) vld_cnt++;
            if (hold_prev) begin
                chk("hold_valid", 64'(m_valid), 64'(1));
                chk("hold_data", 64'(m_data), 64'(hold_data));
                chk("hold_keep", 64'(m_keep), 64'(hold_keep));
            end
            if (m_valid && m_ready) begin
                xfer_cnt++;
                chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    chk("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
                    chk("sb_keep", 64'(m_keep), 64'(exp_keep_q.pop_front()));
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
            hold_keep = m_keep;
        end else begin
            hold_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (pop_now && fq.size() > 0) fifo_dout = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        drive_ready();
    endtask

    task automatic push(input logic [IW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        if (half_vld) begin
            exp_q.push_back({w, half});
            exp_keep_q.push_back(2'b11);
            half_vld = 1'b0;
        end else begin
            half     = w;
            half_vld = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fq.delete();
        exp_q.delete();
        exp_keep_q.delete();
        half_vld   = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        hold_prev  = 1'b0;
        ready_mode = 0;
        m_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_xfers(input string tag, input int target, input int bound);
        int k;
        k = 0;
        while (xfer_cnt < target && k < bound) begin
            cycle();
            k++;
        end
        chk(tag, 64'(xfer_cnt >= target), 64'(1));
    endtask

    initial begin
        int rd_base, vld_base, x_base, pushed, k;

        // Reset values, checked without relying on a clock edge
        rst_n = 1'b0;
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("rst_valid", 64'(m_valid), 64'(0));
        chk("rst_data", 64'(m_data), 64'(0));
        chk("rst_keep", 64'(m_keep), 64'(2'b11));
        chk("rst_cnt", 64'(word_cnt), 64'(0));
        do_reset();

        // Single pair with the sink always ready
        ready_mode = 1;
        m_ready    = 1'b1;
        rd_base  = rd_cnt;
        vld_base = vld_cnt;
        x_base   = xfer_cnt;
        push(16'h1111);
        cycle();
        push(16'h2222);
        wait_xfers("pair_timeout", x_base + 1, 30);
        repeat (6) cycle();
        chk("pair_cnt", 64'(word_cnt), 64'(1));
        chk("pair_rd_pulses", 64'(rd_cnt - rd_base), 64'(2));
        chk("pair_valid_pulses", 64'(vld_cnt - vld_base), 64'(1));
        chk("pair_sb_drained", 64'(exp_q.size()), 64'(0));

        // Reset one cycle after the second pop, while the high half is in flight
        rd_base = rd_cnt;
        push(16'h5555);
        cycle();
        push(16'h6666);
        k = 0;
        while ((rd_cnt - rd_base) < 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("midrd_reach", 64'(rd_cnt - rd_base), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("async_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("async_valid", 64'(m_valid), 64'(0));
        chk("async_data", 64'(m_data), 64'(0));
        chk("async_keep", 64'(m_keep), 64'(2'b11));
        chk("async_cnt", 64'(word_cnt), 64'(0));
        do_reset();
        ready_mode = 1;
        m_ready    = 1'b1;
        x_base = xfer_cnt;
        push(16'h0001);
        cycle();
        push(16'h0002);
        wait_xfers("post_rst_timeout", x_base + 1, 30);
        repeat (3) cycle();
        chk("post_rst_cnt", 64'(word_cnt), 64'(1));

        // Full FIFO with the sink stalled for 20 cycles
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(IW'(16'hA000 + i * 16'h0101));
        rd_base = rd_cnt;
        x_base  = xfer_cnt;
        repeat (20) cycle();
        chk("stall_rd_pulses", 64'(rd_cnt - rd_base), 64'(2));
        chk("stall_valid", 64'(m_valid), 64'(1));
        chk("stall_data", 64'(m_data), 64'({16'hA101, 16'hA000}));
        ready_mode = 1;
        m_ready    = 1'b1;
        wait_xfers("stall_timeout", x_base + 4, 60);
        repeat (5) cycle();
        chk("stall_cnt", 64'(word_cnt), 64'(4));
        chk("stall_fifo_empty", 64'(fq.size()), 64'(0));
        chk("stall_sb_drained", 64'(exp_q.size()), 64'(0));

        // A lone word with nothing following it
        do_reset();
        vld_base = vld_cnt;
        push(16'hABCD);
`ifdef PACKER_FLUSH_TIMEOUT_EN
        exp_q.push_back({16'h0000, 16'hABCD});
        exp_keep_q.push_back(2'b01);
        half_vld = 1'b0;
        k = 0;
        while (!m_valid && k < 25) begin
            cycle();
            k++;
        end
        chk("flush_seen", 64'(m_valid), 64'(1));
        chk("flush_latency_ok", 64'(k <= 18), 64'(1));
        chk("flush_data", 64'(m_data), 64'({16'h0000, 16'hABCD}));
        chk("flush_keep", 64'(m_keep), 64'(2'b01));
        ready_mode = 1;
        m_ready    = 1'b1;
        repeat (3) cycle();
        chk("flush_cnt", 64'(word_cnt), 64'(1));
`else
        repeat (100) cycle();
        chk("lone_no_valid", 64'(vld_cnt - vld_base), 64'(0));
        chk("lone_cnt", 64'(word_cnt), 64'(0));
`endif

        // Empty FIFO throughout
        do_reset();
        rd_base  = rd_cnt;
        vld_base = vld_cnt;
        repeat (50) cycle();
        chk("empty_rd_pulses", 64'(rd_cnt - rd_base), 64'(0));
        chk("empty_valid", 64'(vld_cnt - vld_base), 64'(0));

        // Random traffic: 200 words, sink ready about half the time
        do_reset();
        ready_mode = 2;
        x_base = xfer_cnt;
        pushed = 0;
        k = 0;
        while (xfer_cnt < x_base + 100 && k < 6000) begin
            cycle();
            if (pushed < 200 && fq.size() < DEPTH && $urandom_range(1, 0) == 1) begin
                push(IW'($urandom));
                pushed++;
            end
            k++;
        end
        chk("rand_xfers", 64'(xfer_cnt - x_base), 64'(100));
        ready_mode = 0;
        repeat (5) cycle();
        chk("rand_cnt", 64'(word_cnt), 64'(100));
        chk("rand_sb_drained", 64'(exp_q.size()), 64'(0));
        chk("rand_fifo_empty", 64'(fq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Downstream consumer of the 16-bit synchronous FIFO.
- Pops FIFO words via rd_en/data_out and packs each consecutive pair into one 32-bit word.
- Presents packed words on a valid/ready stream to the next stage.
- Keeps a saturating count of packed words emitted, for bench scoreboarding.

Parameters:
- IN_WIDTH, 16 (FIFO_WIDTH): width of one FIFO word.
- OUT_WIDTH, 32 (2*IN_WIDTH): packed output width; fixed ratio of 2, not independently settable.
- TIMEOUT_CYC, 16: idle cycles before a partial flush (used only with the optional feature).
- CNT_WIDTH, 16: width of the emitted-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  IN_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop request.
- m_data  out  OUT_WIDTH  packed word: {second popped, first popped}.
- m_keep  out  2  half-word valid mask; bit0 = low half.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- word_cnt  out  CNT_WIDTH  packed words accepted; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release), all outputs and state cleared:
  - fifo_rd_en=0, m_valid=0, m_data=0, m_keep=2'b11, word_cnt=0.
  - State S_LO; rd_pend=0; holding registers cleared.
- FIFO read latency:
  - fifo_dout is sampled exactly one cycle after the cycle fifo_rd_en=1.
  - rd_pend marks that cycle.
- Pop rule:
  - fifo_rd_en = (state!=S_OUT) && !fifo_empty && !rd_pend.
  - Never asserted while fifo_empty=1, so no underflow is ever caused.
  - Maximum rate is one pop per 2 cycles.
- States:
  - S_LO: no half held. When rd_pend, capture fifo_dout into lo_q and go to S_HI.
  - S_HI: low half held. When rd_pend:
    - m_data <= {fifo_dout, lo_q}, m_keep <= 2'b11, m_valid <= 1.
    - Go to S_OUT.
  - S_OUT: hold m_data, m_keep and m_valid stable until m_ready.
    - On m_valid && m_ready: m_valid <= 0, word_cnt increments, go to S_LO.
- Handshake:
  - A transfer occurs on the rising edge where m_valid && m_ready.
  - m_valid never drops without a transfer, except on reset.
  - m_ready may be high before m_valid.
  - There is no combinational path from m_ready to fifo_rd_en.
- Throughput: one packed word per 5 cycles minimum. This is accepted; the FIFO absorbs bursts.
- Boundaries:
  - FIFO empty in S_HI: wait indefinitely holding lo_q (unless the optional feature is enabled).
  - word_cnt at max: stays at max.
  - Reset mid-read: in-flight fifo_dout is discarded. Reset mid-S_OUT: the pending word is lost.
  - The FIFO is on the same rst_n.

Optional Feature:
- Macro PACKER_FLUSH_TIMEOUT_EN.
- Defined:
  - In S_HI, an idle counter counts cycles with fifo_empty=1 and !rd_pend; it clears on any pop.
  - On reaching TIMEOUT_CYC, emit {IN_WIDTH'(0), lo_q} with m_keep=2'b01 and go to S_OUT.
  - A partial word also increments word_cnt.
- Undefined: no counter logic; m_keep is constant 2'b11.

Decomposition:
- Shared package Shared_Pkg holds:
  - FIFO_WIDTH and OUT_WIDTH=2*FIFO_WIDTH.
  - typedef enum logic [1:0] {S_LO, S_HI, S_OUT} pack_state_e.
  - typedef logic [OUT_WIDTH-1:0] packed_word_t.
  - Default TIMEOUT_CYC.
- No sub-module needed. The flush counter is a small always_ff inside; a separate module would be a thin wrapper.

Test Plan:
- Push 0x1111 then 0x2222 into FIFO, m_ready=1:
  - m_data=0x2222_1111, m_keep=2'b11, one m_valid pulse.
  - word_cnt=1; fifo_rd_en exactly 2 pulses.
- Push 8 words (FIFO full), m_ready=0 for 20 cycles, then 1:
  - After 2 pops fifo_rd_en stays 0 while stalled; m_data is stable throughout.
  - 4 packed words emitted in order; word_cnt=4; FIFO empty at end.
- Single word 0xABCD, no further pushes:
  - Without macro: no m_valid for 100 cycles.
  - With PACKER_FLUSH_TIMEOUT_EN, TIMEOUT_CYC=16: m_data=0x0000_ABCD, m_keep=2'b01 within 18 cycles.
- FIFO empty throughout, 50 cycles: fifo_rd_en never asserted, m_valid=0.
- Assert rst_n=0 one cycle after fifo_rd_en in S_HI:
  - Outputs return to reset values asynchronously.
  - After release, pushing 0x0001, 0x0002 yields 0x0002_0001.
- Random m_ready (50%) with 200 random words:
  - Scoreboard pairs match the FIFO write order.
  - word_cnt=100; no m_data change while m_valid && !m_ready.
